rot_pixel_streamer: RTL

- Downstream stage of the rotate adapter. While the adapter runs in read/rotate mode, this block samples its 24-bit RGB pixel output once per clock.
- Captured pixels are buffered in a small FIFO and re-emitted on a valid/ready stream carrying start-of-frame, end-of-line and end-of-frame markers.
- It absorbs sink backpressure, which the free-running adapter cannot tolerate.
- It flags any pixel lost to FIFO overflow.

---
 rtl/rot_pixel_streamer_pkg.sv | 21 ++
 rtl/rot_pixel_streamer_fifo.sv | 51 +++++
 rtl/rot_pixel_streamer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rot_pixel_streamer_pkg.sv
// rtl/rot_pixel_streamer_pkg.sv - shared geometry defaults, marker layout and FSM states
package rot_pixel_streamer_pkg;

   localparam int IMG_W = 256;
   localparam int IMG_H = 256;
   localparam int PIX_W = 24;

   // Marker positions inside the 3-bit field stored above the pixel in each FIFO entry
   localparam int SOF_BIT = 2;
   localparam int EOL_BIT = 1;
   localparam int EOF_BIT = 0;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      CAPTURE,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/rot_pixel_streamer_fifo.sv
// rtl/rot_pixel_streamer_fifo.sv - show-ahead synchronous FIFO with registered storage
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_rd   = rd_en && !empty;
   // A simultaneous pop frees the head slot, so a write is accepted even when full
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rot_pixel_streamer.sv
// rtl/rot_pixel_streamer.sv - captures one frame of adapter pixels and re-emits it as a marked stream
module rot_pixel_streamer #(
   parameter int IMG_W      = rot_pixel_streamer_pkg::IMG_W,
   parameter int IMG_H      = rot_pixel_streamer_pkg::IMG_H,
   parameter int PIX_W      = rot_pixel_streamer_pkg::PIX_W,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PIX_W-1:0] pix_in,
   output logic [PIX_W-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_sof,
   output logic             m_eol,
   output logic             m_eof,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   import rot_pixel_streamer_pkg::*;

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(NPIX) + 1;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
   localparam int EW    = PIX_W + 3;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [CNT_W-1:0] pix_cnt;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [2:0]       mark;
   logic [EW-1:0]    wr_entry;
   logic [EW-1:0]    rd_entry;

   assign push = (state == CAPTURE);
   assign pop  = m_valid && m_ready;

   assign mark[SOF_BIT] = (row == '0) && (col == '0);
   assign mark[EOL_BIT] = (col == COL_W'(IMG_W - 1));
   assign mark[EOF_BIT] = mark[EOL_BIT] && (row == ROW_W'(IMG_H - 1));
   assign wr_entry      = {mark, pix_in};

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Outputs are forced to zero when empty so nothing stale leaks out after reset
   assign m_valid = !fifo_empty;
   assign m_data  = m_valid ? rd_entry[PIX_W-1:0] : '0;
   assign m_sof   = m_valid && rd_entry[PIX_W + SOF_BIT];
   assign m_eol   = m_valid && rd_entry[PIX_W + EOL_BIT];
   assign m_eof   = m_valid && rd_entry[PIX_W + EOF_BIT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         col      <= '0;
         row      <= '0;
         pix_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  overflow <= 1'b0;
                  lat_cnt  <= '0;
                  col      <= '0;
                  row      <= '0;
                  pix_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= (RD_LAT == 0) ? CAPTURE : ALIGN;
               end
            end
            ALIGN: begin
               if (lat_cnt == LAT_LAST) begin
                  state <= CAPTURE;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            CAPTURE: begin
               // Counters advance even on a dropped pixel to keep markers geometric
               pix_cnt <= pix_cnt + 1'b1;
               if (col == COL_W'(IMG_W - 1)) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
               if (pix_cnt == CNT_W'(NPIX - 1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
